// File: rtl/seq_table_walker_pkg.sv
// Shared types and helpers for the table walker: FSM state encoding,
// index-width derivation and the power-on contents of each table entry.
package seq_table_walker_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Entry i resets to i modulo 2^width.
    function automatic logic [31:0] init_entry(input int unsigned idx, input int unsigned width);
        return (width >= 32) ? idx : (idx & ((32'd1 << width) - 32'd1));
    endfunction

endpackage

// File: rtl/seq_table_mem.sv
// DEPTH x WIDTH register table: async-reset initialisation, one write port,
// one combinational read port. Out-of-range addresses never touch the array.
module seq_table_mem
    import seq_table_walker_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int DEPTH = 11,
    parameter int AW    = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_hit;

    assign w_wr_hit = wr_en && ({1'b0, wr_addr} < DEPTH_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= WIDTH'(init_entry(i, WIDTH));
            end
        end else if (w_wr_hit) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = ({1'b0, rd_addr} < DEPTH_W) ? r_mem[rd_addr] : '0;

endmodule

// File: rtl/seq_table_walker.sv
// Table walker: a strided wrapping index steps through seq_table_mem and
// emits one (index, entry) beat per advance on a registered valid/ready slot.
module seq_table_walker
    import seq_table_walker_pkg::*;
#(
    parameter int  WIDTH = 6,
    parameter int  DEPTH = 11,
    localparam int AW    = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic [AW-1:0]    step,
    input  logic [AW-1:0]    limit,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    out_idx,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done,
    output state_t           dbg_state
);

    localparam logic [AW:0] LAST_W = (AW+1)'(DEPTH - 1);

    state_t           r_state;
    logic [AW-1:0]    r_idx;
    logic [AW-1:0]    r_step;
    logic [AW-1:0]    r_limit;
    logic             r_oneshot;
    logic             r_final;
    logic             r_out_valid;
    logic [AW-1:0]    r_out_idx;
    logic [WIDTH-1:0] r_out_data;
    logic             r_done;

    logic [WIDTH-1:0] w_rd_data;
    logic [AW:0]      w_sum;
    logic [AW-1:0]    w_limit_clamped;
    logic             w_slot_free;
    logic             w_last;

    seq_table_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (r_idx),
        .rd_data (w_rd_data)
    );

    assign w_limit_clamped = ({1'b0, limit} > LAST_W) ? LAST_W[AW-1:0] : limit;
    assign w_sum           = {1'b0, r_idx} + {1'b0, r_step};
    // A zero stride in one-shot mode would never pass the limit, so it ends the pass too.
    assign w_last          = r_oneshot && ((w_sum > {1'b0, r_limit}) || (r_step == '0));
    // Handshake: a beat transfers on any edge where out_valid & out_ready; the
    // slot holds idx/data stable while out_valid & !out_ready.
    assign w_slot_free     = !r_out_valid || out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_step      <= '0;
            r_limit     <= '0;
            r_oneshot   <= 1'b0;
            r_final     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        r_step    <= step;
                        r_limit   <= w_limit_clamped;
                        r_oneshot <= oneshot;
                        r_idx     <= '0;
                        r_final   <= 1'b0;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state <= S_DRAIN;
                    end else if (w_slot_free) begin
                        r_out_valid <= 1'b1;
                        r_out_idx   <= r_idx;
                        r_out_data  <= w_rd_data;
                        if (w_last) begin
                            r_final <= 1'b1;
                            r_state <= S_DRAIN;
                        end else if (w_sum <= {1'b0, r_limit}) begin
                            r_idx <= w_sum[AW-1:0];
                        end else begin
                            r_idx <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_slot_free) begin
                        r_done  <= r_final && r_out_valid;
                        r_final <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_data  = r_out_data;
    assign done      = r_done;
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_table_walker.sv
// Directed bench for seq_table_walker: accepted beats are collected on the
// falling edge and compared against hand-built expected queues.
module tb_seq_table_walker;
    import seq_table_walker_pkg::*;

    localparam int WIDTH = 6;
    localparam int DEPTH = 11;
    localparam int AW    = 4;
    localparam int BW    = AW + WIDTH;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             oneshot;
    logic [AW-1:0]    step;
    logic [AW-1:0]    limit;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    out_idx;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             done;
    state_t           dbg_state;

    seq_table_walker #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .oneshot   (oneshot),
        .step      (step),
        .limit     (limit),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int unsigned  n_checks = 0;
    int unsigned  n_fail   = 0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] got_q[$];
    int           cyc          = 0;
    int           n_done       = 0;
    int           done_cyc     = 0;
    int           last_acc_cyc = 0;
    int           first_acc_cyc = 0;
    logic         stall_prev   = 1'b0;
    logic [31:0]  prev_slot    = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Falling-edge monitor: records accepted beats, done pulses and stall stability.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (out_valid && out_ready) begin
                if (got_q.size() == 0) first_acc_cyc = cyc;
                got_q.push_back({out_idx, out_data});
                last_acc_cyc = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (stall_prev) begin
                check("stall_hold", {21'b0, out_valid, out_idx, out_data}, prev_slot);
            end
            stall_prev = out_valid && !out_ready;
            prev_slot  = {21'b0, out_valid, out_idx, out_data};
        end else begin
            stall_prev = 1'b0;
        end
    end

    function automatic void push_exp(input int idx, input int data);
        logic [31:0] i_v;
        logic [31:0] d_v;
        i_v = idx;
        d_v = data;
        exp_q.push_back({i_v[AW-1:0], d_v[WIDTH-1:0]});
    endfunction

    task automatic clear_sb();
        got_q.delete();
        exp_q.delete();
        n_done       = 0;
        done_cyc     = 0;
        last_acc_cyc = 0;
        first_acc_cyc = 0;
    endtask

    task automatic compare_beats(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_beat%0d", tag, i), {22'b0, got_q[i]}, {22'b0, exp_q[i]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_walk(input logic os, input logic [AW-1:0] st, input logic [AW-1:0] lim);
        oneshot = os;
        step    = st;
        limit   = lim;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic run_until_idle(input string tag, input int max_cyc, input bit rand_ready);
        int n = 0;
        while (busy && n < max_cyc) begin
            if (rand_ready) out_ready = (n % 3 == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        out_ready = 1'b1;
        check({tag, "_idle"}, {31'b0, busy}, 32'd0);
        tick();
    endtask

    task automatic write_entry(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
        step = '0; limit = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_idx",   {28'b0, out_idx},   32'd0);
        check("rst_data",  {26'b0, out_data},  32'd0);
        check("rst_busy",  {31'b0, busy},      32'd0);
        check("rst_done",  {31'b0, done},      32'd0);
        check("rst_state", {30'b0, dbg_state}, {30'b0, S_IDLE});

        // one-shot full pass, step 1
        clear_sb();
        out_ready = 1'b1;
        start_walk(1'b1, 4'd1, 4'd10);
        check("a_first_valid", {31'b0, out_valid}, 32'd0);
        tick();
        check("a_first_beat", {21'b0, out_valid, out_idx, out_data}, {21'b0, 1'b1, 4'd0, 6'd0});
        run_until_idle("a", 40, 1'b0);
        for (int i = 0; i <= 10; i++) push_exp(i, i);
        check("a_done_cnt", n_done, 1);
        check("a_done_align", done_cyc - last_acc_cyc, 1);
        check("a_span", last_acc_cyc - first_acc_cyc, 10);
        compare_beats("a");

        // continuous, step 3, limit 9, then stop
        clear_sb();
        start_walk(1'b0, 4'd3, 4'd9);
        repeat (10) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("b_drain_state", {30'b0, dbg_state}, {30'b0, S_DRAIN});
        check("b_drain_valid", {31'b0, out_valid}, 32'd0);
        tick();
        check("b_idle", {31'b0, busy}, 32'd0);
        for (int k = 0; k < 10; k++) push_exp((k % 4) * 3, (k % 4) * 3);
        check("b_done_cnt", n_done, 0);
        compare_beats("b");

        // one-shot under pseudo-random backpressure
        clear_sb();
        start_walk(1'b1, 4'd1, 4'd10);
        run_until_idle("c", 300, 1'b1);
        for (int i = 0; i <= 10; i++) push_exp(i, i);
        check("c_done_cnt", n_done, 1);
        compare_beats("c");

        // stop while the slot is stalled: beat held, drained, no done
        clear_sb();
        out_ready = 1'b0;
        start_walk(1'b0, 4'd2, 4'd10);
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("c2_state", {30'b0, dbg_state}, {30'b0, S_DRAIN});
        check("c2_slot", {21'b0, out_valid, out_idx, out_data}, {21'b0, 1'b1, 4'd0, 6'd0});
        tick();
        tick();
        check("c2_hold_state", {30'b0, dbg_state}, {30'b0, S_DRAIN});
        out_ready = 1'b1;
        tick();
        check("c2_idle", {31'b0, busy}, 32'd0);
        tick();
        push_exp(0, 0);
        check("c2_done_cnt", n_done, 0);
        compare_beats("c2");

        // limit above DEPTH-1 clamps to 10
        clear_sb();
        start_walk(1'b1, 4'd1, 4'd15);
        run_until_idle("e", 40, 1'b0);
        for (int i = 0; i <= 10; i++) push_exp(i, i);
        check("e_done_cnt", n_done, 1);
        compare_beats("e");

        // stride 4 with clamped limit: 0,4,8
        clear_sb();
        start_walk(1'b1, 4'd4, 4'd15);
        run_until_idle("e2", 40, 1'b0);
        push_exp(0, 0); push_exp(4, 4); push_exp(8, 8);
        check("e2_done_cnt", n_done, 1);
        compare_beats("e2");

        // step 0 one-shot: exactly one beat
        clear_sb();
        start_walk(1'b1, 4'd0, 4'd10);
        run_until_idle("f", 40, 1'b0);
        push_exp(0, 0);
        check("f_done_cnt", n_done, 1);
        compare_beats("f");

        // table writes during a continuous walk
        clear_sb();
        start_walk(1'b0, 4'd1, 4'd10);
        write_entry(4'd11, 6'h3E);
        tick();
        write_entry(4'd12, 6'h3F);
        tick();
        write_entry(4'd4, 6'h2A);
        repeat (19) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("d_idle", {31'b0, busy}, 32'd0);
        for (int k = 0; k < 24; k++) push_exp(k % 11, ((k % 11) == 4 && k >= 11) ? 6'h2A : (k % 11));
        compare_beats("d");

        // reset mid-run after a write, then start+stop together
        clear_sb();
        start_walk(1'b0, 4'd1, 4'd10);
        write_entry(4'd2, 6'h15);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("g_rst_valid", {31'b0, out_valid}, 32'd0);
        check("g_rst_idx",   {28'b0, out_idx},   32'd0);
        check("g_rst_data",  {26'b0, out_data},  32'd0);
        check("g_rst_busy",  {31'b0, busy},      32'd0);
        check("g_rst_state", {30'b0, dbg_state}, {30'b0, S_IDLE});
        tick();
        rst = 1'b1;
        tick();
        clear_sb();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("g_ss_busy",  {31'b0, busy},      32'd0);
        check("g_ss_state", {30'b0, dbg_state}, {30'b0, S_IDLE});
        tick();
        check("g_ss_valid", {31'b0, out_valid}, 32'd0);
        start_walk(1'b1, 4'd1, 4'd5);
        run_until_idle("g", 40, 1'b0);
        for (int i = 0; i <= 5; i++) push_exp(i, i);
        check("g_done_cnt", n_done, 1);
        compare_beats("g");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_table_walker.md
# seq_table_walker

Parametrised table walker: a DEPTH-entry, WIDTH-bit register table indexed by a programmable-stride wrapping counter. Each advance emits one (index, entry) beat on a valid/ready output port. Supports continuous and one-shot modes, runtime table writes, and downstream backpressure. Serves as a generic sequencer and lookup source for the core's test and bring-up paths.

## Interface
- WIDTH, 6, table entry and output data width
- DEPTH, 11, number of table entries (≥2); AW = $clog2(DEPTH) is a derived localparam, not overridable
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a walk from index 0 when idle
- stop  in  1  pulse; ends the walk after the current beat drains
- oneshot  in  1  sampled at start: 1 = single pass to limit, 0 = wrap forever
- step  in  AW  stride, sampled at start
- limit  in  AW  last valid index, sampled at start, clamped to DEPTH-1
- wr_en  in  1  table write strobe
- wr_addr  in  AW  write index; ignored if ≥ DEPTH
- wr_data  in  WIDTH  write data
- out_valid  out  1  beat available
- out_ready  in  1  downstream accepts beat
- out_idx  out  AW  index of current beat
- out_data  out  WIDTH  table entry at out_idx
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse when a one-shot pass completes

## Operation
- Reset: entry i = i mod 2^WIDTH; all outputs 0; state IDLE; idx = 0.
- States:
  - IDLE: start & !stop → latch step/limit/oneshot, idx = 0, go RUN. start & stop in the same cycle → remain IDLE.
  - RUN: load out slot when slot empty or accepted this cycle, then advance idx.
  - DRAIN: no new loads; wait for pending beat to be accepted, then go IDLE.
- Advance: sum = idx + step, computed in AW+1 bits.
  - sum ≤ limit → idx = sum.
  - sum > limit, continuous mode → idx = 0.
  - sum > limit, oneshot → final beat is loaded, then go DRAIN; done pulses on the cycle that beat is accepted.
- step = 0: idx holds; continuous mode repeats the same entry; oneshot emits exactly one beat.
- Stop in RUN → DRAIN, no further loads. Stop in DRAIN/IDLE is ignored. Start while busy is ignored.
- Output slot: out_valid/out_idx/out_data are registers. They are held stable while out_valid & !out_ready.
- Table write with wr_en and wr_addr < DEPTH: applies at the clock edge. A load of the same index in the same cycle captures the OLD value (read-before-write).
- Reset asserted mid-walk: immediate return to reset state; the table is re-initialised.

## Timing
- Start sampled at edge t → out_valid=1, out_idx=0 after edge t+1.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure: out_ready low → idx frozen, no beat lost or duplicated.
- done and busy fall are registered, coincident with the edge after the final accept.
- Stop sampled at edge t with out_valid=0 → busy low after t+1.

## Structure
- Shared package: state enum (IDLE/RUN/DRAIN), AW derivation function, reset-init function for entries.
- One sub-module, seq_table_mem: a DEPTH×WIDTH register file with async-reset init, one write port and one combinational read port. FSM, counter and out slot live in seq_table_walker.

## Test plan
- Reset then start, oneshot=1, step=1, limit=10, out_ready=1 → beats idx 0..10 with data 0..10 on consecutive cycles; done pulses with idx 10 accepted; busy low after.
- Continuous mode, step=3, limit=9 → idx 0,3,6,9,0,3… After stop, the pending beat drains and busy drops.
- out_ready toggled 1/0 pseudo-randomly → accepted sequence identical to the no-stall case; outputs stable during stalls.
- Write 0x2A to idx 4 while walking with step=1 → the concurrent load of idx 4 shows 4; the next pass shows 0x2A. A write to addr 12 has no effect.
- limit=15 (above DEPTH-1) with oneshot → clamped; last beat idx 10. step=0 oneshot → single beat idx 0, then done.
- Assert rst mid-run after a table write → outputs 0, state IDLE, entries back to i. start with stop in the same cycle → stays IDLE.
